// File: rtl/alu_serial_sequencer_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings, control
// word layout and sequencer state encoding.
package alu_serial_sequencer_pkg;

  // ALUCtrl is {AInvert, BInvert, Op[2:0]}
  localparam int unsigned CTRL_W     = 5;
  localparam int unsigned CTRL_AINV  = 4;
  localparam int unsigned CTRL_BINV  = 3;
  localparam int unsigned CTRL_OP_HI = 2;
  localparam int unsigned CTRL_OP_LO = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [2:0] op;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

endpackage

// File: rtl/alu_serial_sequencer_if.sv
// Request/response bundle between the control unit (master) and the serial
// ALU sequencer (slave).
interface alu_serial_sequencer_if
  import alu_serial_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 24
);
  logic              start;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              carry_out;
  logic              overflow;

  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, result, zero, carry_out, overflow
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, result, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_serial_sequencer_alu1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/ADD/SLT/XOR select.
// The raw adder sum is exported separately so SLT can use it.
module alu_serial_sequencer_alu1bit
  import alu_serial_sequencer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       carry_out,
  output logic       sum
);

  logic a_eff;
  logic b_eff;

  // Slice datapath and op select
  always_comb begin
    a_eff     = a ^ a_invert;
    b_eff     = b ^ b_invert;
    sum       = a_eff ^ b_eff ^ carry_in;
    carry_out = (a_eff & b_eff) | (carry_in & (a_eff ^ b_eff));
    result    = 1'b0;
    case (op)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      OP_SLT:  result = less;
      OP_XOR:  result = a_eff ^ b_eff;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one operand bit per clock through a single slice,
// LSB first, with a registered carry; flags and SLT resolved in a final cycle.
module alu_serial_sequencer
  import alu_serial_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 24
)(
  input logic                   clk,
  input logic                   rst,
  alu_serial_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic slice_result;
  logic slice_carry;
  logic slice_sum;

  // Less is tied low; SLT is resolved from the sum shift register at the end
  alu_serial_sequencer_alu1bit u_slice (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .carry_in  (carry_q),
    .a_invert  (ctrl_q.a_invert),
    .b_invert  (ctrl_q.b_invert),
    .less      (1'b0),
    .op        (ctrl_q.op),
    .result    (slice_result),
    .carry_out (slice_carry),
    .sum       (slice_sum)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      r_sh_q      <= '0;
      s_sh_q      <= '0;
      ctrl_q      <= '0;
      carry_q     <= 1'b0;
      cin_msb_q   <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      r_sh_q      <= r_sh_d;
      s_sh_q      <= s_sh_d;
      ctrl_q      <= ctrl_d;
      carry_q     <= carry_d;
      cin_msb_q   <= cin_msb_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  // Next-state and sequencing: accept, shift one bit per clock, then resolve
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    r_sh_d      = r_sh_q;
    s_sh_d      = s_sh_q;
    ctrl_d      = ctrl_q;
    carry_d     = carry_q;
    cin_msb_d   = cin_msb_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          ctrl_d  = alu_ctrl_t'(bus.alu_ctrl);
          // Carry seeded with BInvert turns ADD into SUB
          carry_d = bus.alu_ctrl[CTRL_BINV];
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = {slice_result, r_sh_q[WIDTH-1:1]};
        s_sh_d  = {slice_sum, s_sh_q[WIDTH-1:1]};
        carry_d = slice_carry;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          cin_msb_d = carry_q;
          state_d   = StFinish;
        end
      end
      StFinish: begin
        overflow_d  = cin_msb_q ^ carry_q;
        carry_out_d = carry_q;
        if (ctrl_q.op == OP_SLT) begin
          result_d = {{(WIDTH - 1){1'b0}}, s_sh_q[WIDTH-1] ^ cin_msb_q ^ carry_q};
        end else begin
          result_d = r_sh_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for the serial ALU sequencer: directed cases plus
// randomized ops against a word-level arithmetic model.
module tb_alu_serial_sequencer;
  localparam int unsigned W = 24;

  logic clk = 1'b0;
  logic rst;

  alu_serial_sequencer_if #(.WIDTH(W)) bus ();

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] held_result;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: whole-operand arithmetic, signed-overflow rule
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] ctrl, output logic [W-1:0] res,
                                output logic cout, output logic ovf);
    logic [W-1:0] ae, be, sum;
    logic [W:0]   full;
    ae   = ctrl[4] ? ~a : a;
    be   = ctrl[3] ? ~b : b;
    full = {1'b0, ae} + {1'b0, be} + {{W{1'b0}}, ctrl[3]};
    sum  = full[W-1:0];
    cout = full[W];
    ovf  = (ae[W-1] == be[W-1]) && (sum[W-1] != ae[W-1]);
    case (ctrl[2:0])
      3'd0:    res = ae & be;
      3'd1:    res = ae | be;
      3'd2:    res = sum;
      3'd3:    res = {{(W - 1){1'b0}}, sum[W-1] ^ ovf};
      3'd4:    res = ae ^ be;
      default: res = '0;
    endcase
  endfunction

  // Issue one op starting now (#1 after an edge); returns in the Done cycle
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] ctrl, input bit disturb);
    logic [W-1:0] er;
    logic         ec, eo;
    int           n;
    bit           seen;
    model(a, b, ctrl, er, ec, eo);
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.alu_ctrl = ctrl;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".busy"}, 64'(bus.busy), 64'(1));
    check({tag, ".held"}, 64'(bus.result), 64'(held_result));
    seen = 1'b0;
    n    = 1;
    while (!seen && n <= int'(W) + 5) begin
      if (disturb) begin
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.alu_ctrl = 5'($urandom_range(0, 31));
        bus.start    = (n == 5 || n == 10);
      end
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
      else n++;
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 64'(seen), 64'(1));
    if (seen) begin
      check({tag, ".latency"}, 64'(n), 64'(W + 1));
      check({tag, ".result"}, 64'(bus.result), 64'(er));
      check({tag, ".zero"}, 64'(bus.zero), 64'(er == '0));
      check({tag, ".cout"}, 64'(bus.carry_out), 64'(ec));
      check({tag, ".ovf"}, 64'(bus.overflow), 64'(eo));
      check({tag, ".busy_lo"}, 64'(bus.busy), 64'(0));
      held_result = er;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("idle.done", 64'(bus.done), 64'(0));
    end
  endtask

  initial begin
    int dones;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_ctrl = '0;
    held_result  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.done", 64'(bus.done), 64'(0));
    check("rst.result", 64'(bus.result), 64'(0));
    check("rst.zero", 64'(bus.zero), 64'(1));
    check("rst.cout", 64'(bus.carry_out), 64'(0));
    check("rst.ovf", 64'(bus.overflow), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add", 24'h000001, 24'hFFFFFF, 5'b00010, 1'b0); idle(1);
    run_op("sub", 24'h7FFFFF, 24'hFFFFFF, 5'b01010, 1'b0); idle(1);
    run_op("slt_neg", 24'hFFFFFB, 24'h000003, 5'b01011, 1'b0); idle(1);
    run_op("slt_ovf", 24'h800000, 24'h000001, 5'b01011, 1'b0); idle(1);
    run_op("slt_ge", 24'h000003, 24'hFFFFFB, 5'b01011, 1'b0); idle(1);
    run_op("nor", 24'h0F0F0F, 24'h00FF00, 5'b11000, 1'b0); idle(1);
    run_op("xor", 24'h0F0F0F, 24'h00FF00, 5'b00100, 1'b0); idle(1);
    run_op("nand", 24'hF0F0F0, 24'hFF00FF, 5'b11001, 1'b0); idle(1);
    run_op("disturb", 24'h123456, 24'h00ABCD, 5'b00010, 1'b1); idle(1);

    // Start held in the Done cycle must launch the next op
    run_op("b2b0", 24'hABCDEF, 24'h111111, 5'b00010, 1'b0);
    run_op("b2b1", 24'h00F00F, 24'h0FF0F0, 5'b00001, 1'b0);
    idle(1);

    // Asynchronous reset in the middle of RUN
    bus.start    = 1'b1;
    bus.a        = 24'h345678;
    bus.b        = 24'h000123;
    bus.alu_ctrl = 5'b00010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst.busy", 64'(bus.busy), 64'(0));
    check("mid_rst.done", 64'(bus.done), 64'(0));
    check("mid_rst.result", 64'(bus.result), 64'(0));
    check("mid_rst.zero", 64'(bus.zero), 64'(1));
    check("mid_rst.cout", 64'(bus.carry_out), 64'(0));
    check("mid_rst.ovf", 64'(bus.overflow), 64'(0));
    @(posedge clk); #1;
    rst         = 1'b0;
    held_result = '0;
    dones       = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("mid_rst.no_done", 64'(dones), 64'(0));
    run_op("post_rst", 24'h345678, 24'h000123, 5'b01010, 1'b0); idle(1);

    // Randomized ops, occasionally back-to-back or with noisy inputs
    for (int i = 0; i < 30; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 5'($urandom_range(0, 31)),
             bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
